// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the register-file writeback unit
// Contents:
//   DATA_BITS, ADDR_BITS : register width and register address width
//   ZERO_REG             : hardwired-zero register address
//   wb_entry_t           : queued long-latency result {live, addr, data}
//   sel_e                : write-port source for the current cycle
package wb_pkg;
   localparam int DATA_BITS = 32;
   localparam int ADDR_BITS = 5;

   localparam logic [ADDR_BITS-1:0] ZERO_REG = '0;

   // live is cleared when a younger ALU write to the same register supersedes this entry
   typedef struct packed {
      logic                 live;
      logic [ADDR_BITS-1:0] addr;
      logic [DATA_BITS-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE  = 2'd0,
      SEL_ALU   = 2'd1,
      SEL_QUEUE = 2'd2,
      SEL_LONG  = 2'd3
   } sel_e;
endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - bundle of ALU/long-latency inputs, register-file write port and pending lookups
// Modports:
//   master : result producers / decode side (drives results and lookup addresses)
//   slave  : writeback unit (accepts results, drives write port, LongReady, pending, count)
interface wb_if #(
   parameter int QUEUE_DEPTH = 4
);
   import wb_pkg::*;

   localparam int CNT_BITS = $clog2(QUEUE_DEPTH) + 1;

   logic                 AluValid;
   logic [ADDR_BITS-1:0] AluAddress;
   logic [DATA_BITS-1:0] AluData;
   logic                 LongValid;
   logic                 LongReady;
   logic [ADDR_BITS-1:0] LongAddress;
   logic [DATA_BITS-1:0] LongData;
   logic                 WriteEnable;
   logic [ADDR_BITS-1:0] DAddress;
   logic [DATA_BITS-1:0] DData;
   logic [ADDR_BITS-1:0] AAddress;
   logic [ADDR_BITS-1:0] BAddress;
   logic                 APending;
   logic                 BPending;
   logic [CNT_BITS-1:0]  QueueCount;

   modport master (
      output AluValid, AluAddress, AluData,
      output LongValid, LongAddress, LongData,
      output AAddress, BAddress,
      input  LongReady, WriteEnable, DAddress, DData,
      input  APending, BPending, QueueCount
   );

   modport slave (
      input  AluValid, AluAddress, AluData,
      input  LongValid, LongAddress, LongData,
      input  AAddress, BAddress,
      output LongReady, WriteEnable, DAddress, DData,
      output APending, BPending, QueueCount
   );
endinterface

// File: rtl/wb_queue.sv
// rtl/wb_queue.sv - circular FIFO of long-latency results with kill-by-address and live lookups
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   i_push, i_push_entry     : enqueue an entry (ignored when full)
//   i_pop                    : dequeue the head (ignored when empty)
//   i_kill, i_kill_addr      : clear live bit of every occupied entry with this address
//   i_lookup_a/b, o_match_a/b: occupied live entry with matching address exists
//   o_head                   : entry at the read pointer
//   o_full, o_empty, o_count : occupancy (killed entries still count)
module wb_queue
   import wb_pkg::*;
#(
   parameter  int DEPTH    = 4,
   localparam int PTR_BITS = $clog2(DEPTH),
   localparam int CNT_BITS = PTR_BITS + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_push,
   input  wb_entry_t            i_push_entry,
   input  logic                 i_pop,
   input  logic                 i_kill,
   input  logic [ADDR_BITS-1:0] i_kill_addr,
   input  logic [ADDR_BITS-1:0] i_lookup_a,
   input  logic [ADDR_BITS-1:0] i_lookup_b,
   output wb_entry_t            o_head,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [CNT_BITS-1:0]  o_count,
   output logic                 o_match_a,
   output logic                 o_match_b
);
   wb_entry_t            r_mem [DEPTH];
   logic [DEPTH-1:0]     r_occ;
   logic [PTR_BITS-1:0]  r_rd_ptr;
   logic [PTR_BITS-1:0]  r_wr_ptr;
   logic [CNT_BITS-1:0]  r_count;
   logic                 w_do_push;
   logic                 w_do_pop;

   assign o_full    = (r_count == CNT_BITS'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_occ    <= '0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         // Kill first; a same-edge push lands on a free slot so it is never affected.
         for (int i = 0; i < DEPTH; i++) begin
            if (i_kill && r_occ[i] && r_mem[i].addr == i_kill_addr) r_mem[i].live <= 1'b0;
         end
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_entry;
            r_occ[r_wr_ptr] <= 1'b1;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_occ[r_rd_ptr] <= 1'b0;
            r_rd_ptr        <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      o_match_a = 1'b0;
      o_match_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_occ[i] && r_mem[i].live && r_mem[i].addr == i_lookup_a) o_match_a = 1'b1;
         if (r_occ[i] && r_mem[i].live && r_mem[i].addr == i_lookup_b) o_match_b = 1'b1;
      end
   end
endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU and long-latency results onto the register file write port
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_if.slave - ALU/long inputs, LongReady, registered WriteEnable/DAddress/DData,
//              decode pending lookups (AAddress/BAddress -> APending/BPending), QueueCount
module writeback_unit
   import wb_pkg::*;
#(
   parameter int QUEUE_DEPTH = 4
) (
   input  logic clk,
   input  logic rst,
   wb_if.slave  bus
);
   localparam int CNT_BITS = $clog2(QUEUE_DEPTH) + 1;

   sel_e                 w_sel;
   logic                 w_alu_wr;
   logic                 w_long_xfer;
   logic                 w_long_nz;
   logic                 w_push;
   logic                 w_pop;
   wb_entry_t            w_head;
   wb_entry_t            w_push_entry;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_match_a;
   logic                 w_match_b;
   logic [CNT_BITS-1:0]  w_count;

   logic                 r_we;
   logic [ADDR_BITS-1:0] r_daddr;
   logic [DATA_BITS-1:0] r_ddata;

   assign bus.LongReady = !rst && !w_full;
   assign w_alu_wr      = bus.AluValid && (bus.AluAddress != ZERO_REG);
   assign w_long_xfer   = bus.LongValid && bus.LongReady;
   assign w_long_nz     = bus.LongAddress != ZERO_REG;

   always_comb begin
      w_sel = SEL_NONE;
      if (w_alu_wr)                    w_sel = SEL_ALU;
      else if (!w_empty)               w_sel = SEL_QUEUE;
      else if (w_long_xfer && w_long_nz) w_sel = SEL_LONG;
   end

   // A long result to the register the ALU writes this cycle is already stale: drop it.
   assign w_push = w_long_xfer && w_long_nz && (w_sel != SEL_LONG) &&
                   !(w_alu_wr && bus.LongAddress == bus.AluAddress);
   assign w_pop  = (w_sel == SEL_QUEUE);
   assign w_push_entry = '{live: 1'b1, addr: bus.LongAddress, data: bus.LongData};

   wb_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
      .clk          (clk),
      .rst          (rst),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .i_kill       (w_alu_wr),
      .i_kill_addr  (bus.AluAddress),
      .i_lookup_a   (bus.AAddress),
      .i_lookup_b   (bus.BAddress),
      .o_head       (w_head),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (w_count),
      .o_match_a    (w_match_a),
      .o_match_b    (w_match_b)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_daddr <= '0;
         r_ddata <= '0;
      end else begin
         case (w_sel)
            SEL_ALU: begin
               r_we    <= 1'b1;
               r_daddr <= bus.AluAddress;
               r_ddata <= bus.AluData;
            end
            SEL_QUEUE: begin
               // A killed head still takes its slot on the port, producing a bubble.
               r_we    <= w_head.live;
               r_daddr <= w_head.addr;
               r_ddata <= w_head.data;
            end
            SEL_LONG: begin
               r_we    <= 1'b1;
               r_daddr <= bus.LongAddress;
               r_ddata <= bus.LongData;
            end
            default: r_we <= 1'b0;
         endcase
      end
   end

   assign bus.WriteEnable = r_we;
   assign bus.DAddress    = r_daddr;
   assign bus.DData       = r_ddata;
   assign bus.QueueCount  = w_count;

   assign bus.APending = (bus.AAddress != ZERO_REG) &&
                         (w_match_a || (r_we && r_daddr == bus.AAddress));
   assign bus.BPending = (bus.BAddress != ZERO_REG) &&
                         (w_match_b || (r_we && r_daddr == bus.BAddress));
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit
module tb_writeback_unit;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   wb_if #(.QUEUE_DEPTH(4)) bus ();
   writeback_unit #(.QUEUE_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic        live;
      logic [4:0]  addr;
      logic [31:0] data;
   } m_ent_t;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.AluValid = 0; bus.AluAddress = 0; bus.AluData = 0;
      bus.LongValid = 0; bus.LongAddress = 0; bus.LongData = 0;
      bus.AAddress = 0; bus.BAddress = 0;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst = 1; bus.LongValid = 1; bus.LongAddress = 5; bus.LongData = 32'h1234;
      step(); step();
      n_checks++; if (bus.LongReady !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.LongReady); else n_pass++;
      n_checks++; if (bus.WriteEnable !== 1'b0) $display("FAIL reset_we got %b want 0", bus.WriteEnable); else n_pass++;
      n_checks++; if (bus.DAddress !== 5'd0) $display("FAIL reset_daddr got %0d want 0", bus.DAddress); else n_pass++;
      n_checks++; if (bus.DData !== 32'd0) $display("FAIL reset_ddata got %h want 0", bus.DData); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.QueueCount); else n_pass++;
      rst = 0; bus.LongValid = 0;
      step();
   endtask

   task automatic test_direct_long;
      bus.LongValid = 1; bus.LongAddress = 5; bus.LongData = 32'hDEADBEEF;
      n_checks++; if (bus.LongReady !== 1'b1) $display("FAIL direct_ready got %b want 1", bus.LongReady); else n_pass++;
      step();
      bus.LongValid = 0;
      n_checks++; if (bus.WriteEnable !== 1'b1) $display("FAIL direct_we got %b want 1", bus.WriteEnable); else n_pass++;
      n_checks++; if (bus.DAddress !== 5'd5) $display("FAIL direct_daddr got %0d want 5", bus.DAddress); else n_pass++;
      n_checks++; if (bus.DData !== 32'hDEADBEEF) $display("FAIL direct_ddata got %h want deadbeef", bus.DData); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd0) $display("FAIL direct_count got %0d want 0", bus.QueueCount); else n_pass++;
      step();
      n_checks++; if (bus.WriteEnable !== 1'b0) $display("FAIL direct_idle_we got %b want 0", bus.WriteEnable); else n_pass++;
   endtask

   task automatic test_collision;
      bus.AluValid = 1; bus.AluAddress = 3; bus.AluData = 32'h11;
      bus.LongValid = 1; bus.LongAddress = 7; bus.LongData = 32'h22;
      step();
      idle_inputs();
      n_checks++; if (bus.WriteEnable !== 1'b1 || bus.DAddress !== 5'd3 || bus.DData !== 32'h11)
         $display("FAIL coll_alu got we=%b a=%0d d=%h want we=1 a=3 d=11", bus.WriteEnable, bus.DAddress, bus.DData); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd1) $display("FAIL coll_count1 got %0d want 1", bus.QueueCount); else n_pass++;
      step();
      n_checks++; if (bus.WriteEnable !== 1'b1 || bus.DAddress !== 5'd7 || bus.DData !== 32'h22)
         $display("FAIL coll_long got we=%b a=%0d d=%h want we=1 a=7 d=22", bus.WriteEnable, bus.DAddress, bus.DData); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd0) $display("FAIL coll_count0 got %0d want 0", bus.QueueCount); else n_pass++;
      step();
   endtask

   task automatic test_full;
      for (int i = 0; i < 4; i++) begin
         bus.AluValid = 1; bus.AluAddress = 5'(i + 1); bus.AluData = 32'(i);
         bus.LongValid = 1; bus.LongAddress = 5'(21 + i); bus.LongData = 32'(100 + i);
         n_checks++; if (bus.LongReady !== 1'b1) $display("FAIL full_ready_%0d got %b want 1", i, bus.LongReady); else n_pass++;
         step();
      end
      idle_inputs();
      n_checks++; if (bus.QueueCount !== 3'd4) $display("FAIL full_count got %0d want 4", bus.QueueCount); else n_pass++;
      n_checks++; if (bus.LongReady !== 1'b0) $display("FAIL full_ready got %b want 0", bus.LongReady); else n_pass++;
      for (int j = 0; j < 4; j++) begin
         step();
         n_checks++; if (bus.WriteEnable !== 1'b1 || bus.DAddress !== 5'(21 + j) || bus.DData !== 32'(100 + j))
            $display("FAIL full_pop_%0d got we=%b a=%0d d=%0d want we=1 a=%0d d=%0d", j,
                     bus.WriteEnable, bus.DAddress, bus.DData, 21 + j, 100 + j); else n_pass++;
         n_checks++; if (bus.QueueCount !== 3'(3 - j)) $display("FAIL full_popcnt_%0d got %0d want %0d", j, bus.QueueCount, 3 - j); else n_pass++;
         n_checks++; if (bus.LongReady !== 1'b1) $display("FAIL full_reready_%0d got %b want 1", j, bus.LongReady); else n_pass++;
      end
      step();
   endtask

   task automatic test_waw_kill;
      bus.AluValid = 1; bus.AluAddress = 2; bus.AluData = 32'h1;
      bus.LongValid = 1; bus.LongAddress = 9; bus.LongData = 32'hAA;
      step();
      bus.AluAddress = 9; bus.AluData = 32'hBB; bus.LongValid = 0; bus.BAddress = 9;
      #1;
      n_checks++; if (bus.BPending !== 1'b1) $display("FAIL waw_pend_before got %b want 1", bus.BPending); else n_pass++;
      step();
      bus.AluValid = 0;
      n_checks++; if (bus.WriteEnable !== 1'b1 || bus.DAddress !== 5'd9 || bus.DData !== 32'hBB)
         $display("FAIL waw_alu got we=%b a=%0d d=%h want we=1 a=9 d=bb", bus.WriteEnable, bus.DAddress, bus.DData); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd1) $display("FAIL waw_count got %0d want 1", bus.QueueCount); else n_pass++;
      step();
      n_checks++; if (bus.WriteEnable !== 1'b0) $display("FAIL waw_bubble got %b want 0", bus.WriteEnable); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd0) $display("FAIL waw_count0 got %0d want 0", bus.QueueCount); else n_pass++;
      n_checks++; if (bus.BPending !== 1'b0) $display("FAIL waw_pend_after got %b want 0", bus.BPending); else n_pass++;
      idle_inputs();
      step();
   endtask

   task automatic test_zero_pending;
      bus.LongValid = 1; bus.LongAddress = 0; bus.LongData = 32'h55;
      step();
      bus.LongValid = 0;
      n_checks++; if (bus.WriteEnable !== 1'b0) $display("FAIL zero_we got %b want 0", bus.WriteEnable); else n_pass++;
      n_checks++; if (bus.QueueCount !== 3'd0) $display("FAIL zero_count got %0d want 0", bus.QueueCount); else n_pass++;
      bus.AluValid = 1; bus.AluAddress = 1; bus.AluData = 32'h1;
      bus.LongValid = 1; bus.LongAddress = 12; bus.LongData = 32'h77;
      step();
      bus.AluValid = 0; bus.LongValid = 0; bus.AAddress = 12;
      #1;
      n_checks++; if (bus.APending !== 1'b1) $display("FAIL pend_a12 got %b want 1", bus.APending); else n_pass++;
      bus.AAddress = 0;
      #1;
      n_checks++; if (bus.APending !== 1'b0) $display("FAIL pend_a0 got %b want 0", bus.APending); else n_pass++;
      step();
      n_checks++; if (bus.WriteEnable !== 1'b1 || bus.DAddress !== 5'd12 || bus.DData !== 32'h77)
         $display("FAIL pend_drain got we=%b a=%0d d=%h want we=1 a=12 d=77", bus.WriteEnable, bus.DAddress, bus.DData); else n_pass++;
      step();
   endtask

   task automatic test_random;
      m_ent_t      m_q[$];
      m_ent_t      e;
      logic        m_we;
      logic [4:0]  m_da;
      logic [31:0] m_dd;
      logic        rst_now, exp_ready, exp_pa, exp_pb, xfer, aw, direct;

      idle_inputs();
      rst = 1; step(); rst = 0;
      m_we = 0; m_da = 0; m_dd = 0;
      for (int c = 0; c < 300; c++) begin
         rst_now = (c == 150);
         rst = rst_now;
         bus.AluValid = 1'($urandom_range(0, 1));
         bus.AluAddress = 5'($urandom_range(0, 7));
         bus.AluData = $urandom;
         bus.LongValid = ($urandom_range(0, 9) < 6);
         bus.LongAddress = 5'($urandom_range(0, 7));
         bus.LongData = $urandom;
         bus.AAddress = 5'($urandom_range(0, 7));
         bus.BAddress = 5'($urandom_range(0, 7));
         #1;
         exp_ready = !rst_now && (m_q.size() < 4);
         n_checks++; if (bus.LongReady !== exp_ready) $display("FAIL rnd_ready c=%0d got %b want %b", c, bus.LongReady, exp_ready); else n_pass++;
         if (!rst_now) begin
            exp_pa = 0; exp_pb = 0;
            foreach (m_q[k]) begin
               if (m_q[k].live && m_q[k].addr == bus.AAddress) exp_pa = 1;
               if (m_q[k].live && m_q[k].addr == bus.BAddress) exp_pb = 1;
            end
            if (m_we && m_da == bus.AAddress) exp_pa = 1;
            if (m_we && m_da == bus.BAddress) exp_pb = 1;
            if (bus.AAddress == 0) exp_pa = 0;
            if (bus.BAddress == 0) exp_pb = 0;
            n_checks++; if (bus.APending !== exp_pa) $display("FAIL rnd_apend c=%0d got %b want %b", c, bus.APending, exp_pa); else n_pass++;
            n_checks++; if (bus.BPending !== exp_pb) $display("FAIL rnd_bpend c=%0d got %b want %b", c, bus.BPending, exp_pb); else n_pass++;
         end
         if (rst_now) begin
            m_q.delete(); m_we = 0; m_da = 0; m_dd = 0;
         end else begin
            xfer = bus.LongValid && exp_ready;
            aw = bus.AluValid && bus.AluAddress != 0;
            direct = 0;
            if (aw) begin
               foreach (m_q[k]) if (m_q[k].addr == bus.AluAddress) m_q[k].live = 0;
               m_we = 1; m_da = bus.AluAddress; m_dd = bus.AluData;
            end else if (m_q.size() > 0) begin
               e = m_q.pop_front();
               m_we = e.live; m_da = e.addr; m_dd = e.data;
            end else if (xfer && bus.LongAddress != 0) begin
               m_we = 1; m_da = bus.LongAddress; m_dd = bus.LongData; direct = 1;
            end else begin
               m_we = 0;
            end
            if (xfer && bus.LongAddress != 0 && !direct && !(aw && bus.LongAddress == bus.AluAddress))
               m_q.push_back('{live: 1'b1, addr: bus.LongAddress, data: bus.LongData});
         end
         step();
         n_checks++; if (bus.WriteEnable !== m_we) $display("FAIL rnd_we c=%0d got %b want %b", c, bus.WriteEnable, m_we); else n_pass++;
         if (m_we) begin
            n_checks++; if (bus.DAddress !== m_da || bus.DData !== m_dd)
               $display("FAIL rnd_wdata c=%0d got a=%0d d=%h want a=%0d d=%h", c, bus.DAddress, bus.DData, m_da, m_dd); else n_pass++;
         end
         n_checks++; if (bus.QueueCount !== 3'(m_q.size())) $display("FAIL rnd_count c=%0d got %0d want %0d", c, bus.QueueCount, m_q.size()); else n_pass++;
      end
      rst = 0;
      idle_inputs();
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_direct_long();
      test_collision();
      test_full();
      test_waw_kill();
      test_zero_pending();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
